// File: rtl/keyword_pkg.sv
// keyword_pkg: keyword characters, case offset and FSM state encodings shared by the keyword tx and detectors
package keyword_pkg;
    localparam int KW_LEN = 6;
    localparam logic [7:0] KW_CHARS [0:KW_LEN-1] = '{8'h63, 8'h73, 8'h63, 8'h6f, 8'h72, 8'h65};
    localparam logic [7:0] CASE_OFFSET = 8'h20;
    localparam logic [2:0] LAST_IDX = 3'(KW_LEN - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_SEP} state_t;
endpackage

// File: rtl/char_case_sel.sv
// char_case_sel: picks keyword character idx and uppercases it when its case_mask bit is set
module char_case_sel
    import keyword_pkg::*;
(
    input  logic [2:0] idx,
    input  logic [5:0] case_mask,
    output logic [7:0] char_sel
);
    assign char_sel = case_mask[idx] ? KW_CHARS[idx] - CASE_OFFSET : KW_CHARS[idx];
endmodule

// File: rtl/keyword_char_tx.sv
// keyword_char_tx: streams the keyword N times over a valid/ready byte interface,
// with per-character case selection and an optional separator between repetitions
module keyword_char_tx
    import keyword_pkg::*;
#(
    parameter int REP_W = 4,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [5:0]       case_mask,
    input  logic             sep_en,
    input  logic             abort,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [2:0]       idx;
    logic [REP_W-1:0] rep_left;
    logic [5:0]       mask_q;
    logic             sep_q;
    logic [2:0]       sel_idx;
    logic [5:0]       sel_mask;
    logic [7:0]       sel_char;

    // look ahead to the character presented after the next load so char_out stays registered
    assign sel_idx  = (state == ST_SEND && idx != LAST_IDX) ? idx + 3'd1 : 3'd0;
    assign sel_mask = (state == ST_IDLE) ? case_mask : mask_q;

    char_case_sel u_sel (.idx(sel_idx), .case_mask(sel_mask), .char_sel(sel_char));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            rep_left   <= '0;
            mask_q     <= '0;
            sep_q      <= 1'b0;
            char_out   <= '0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && rep_cnt != '0) begin
                        rep_left   <= rep_cnt;
                        mask_q     <= case_mask;
                        sep_q      <= sep_en;
                        idx        <= '0;
                        char_out   <= sel_char;
                        char_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_SEND;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        char_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (char_ready) begin
                        if (idx != LAST_IDX) begin
                            idx      <= idx + 3'd1;
                            char_out <= sel_char;
                        end else if (rep_left == REP_W'(1)) begin
                            char_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            rep_left <= rep_left - REP_W'(1);
                            idx      <= '0;
                            char_out <= sep_q ? SEP_CHAR : sel_char;
                            state    <= sep_q ? ST_SEP : ST_SEND;
                        end
                    end
                end
                ST_SEP: begin
                    if (abort) begin
                        char_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (char_ready) begin
                        idx      <= '0;
                        char_out <= sel_char;
                        state    <= ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
